// File: rtl/vga_timing_sequencer.sv
// Programmable VGA raster sequencer: segment FSMs drive sync/DE/coords; shadow timing bank applied at frame wrap.
// Outputs are registered one clock after the sampled enable; no backpressure, the raster free-runs while i_en is high.
module vga_timing_sequencer #(
    parameter int CNT_WIDTH     = 10,
    parameter int H_VISIBLE     = 640,
    parameter int H_FRONT_PORCH = 16,
    parameter int H_SYNC        = 96,
    parameter int H_BACK_PORCH  = 48,
    parameter int V_VISIBLE     = 480,
    parameter int V_FRONT_PORCH = 10,
    parameter int V_SYNC        = 2,
    parameter int V_BACK_PORCH  = 33,
    parameter int SYNC_ACTIVE   = 0
) (
    input  logic                 i_clk,
    input  logic                 i_rst_n,
    input  logic                 i_en,
    input  logic                 i_cfg_wr,
    input  logic [2:0]           i_cfg_addr,
    input  logic [CNT_WIDTH-1:0] i_cfg_data,
    input  logic                 i_cfg_commit,
    output logic                 o_cfg_pending,
    output logic                 o_h_sync,
    output logic                 o_v_sync,
    output logic                 o_de,
    output logic [CNT_WIDTH-1:0] o_x,
    output logic [CNT_WIDTH-1:0] o_y,
    output logic                 o_line_start,
    output logic                 o_frame_start
);
    localparam int W = CNT_WIDTH;
    localparam logic [W-1:0] ONE = W'(1);
    localparam logic SYNC_ON = (SYNC_ACTIVE != 0);

    typedef enum logic [1:0] {HS_VIS, HS_FP, HS_SYNC, HS_BP} h_state_e;
    typedef enum logic [1:0] {VS_VIS, VS_FP, VS_SYNC, VS_BP} v_state_e;

    function automatic logic [W-1:0] dflt(input int idx);
        case (idx)
            0:       return W'(H_VISIBLE);
            1:       return W'(H_FRONT_PORCH);
            2:       return W'(H_SYNC);
            3:       return W'(H_BACK_PORCH);
            4:       return W'(V_VISIBLE);
            5:       return W'(V_FRONT_PORCH);
            6:       return W'(V_SYNC);
            default: return W'(V_BACK_PORCH);
        endcase
    endfunction

    // Index of the last clock/line of a segment; a zero-length field still lasts one.
    function automatic logic [W-1:0] last_of(input logic [W-1:0] f);
        return (f == '0) ? '0 : f - ONE;
    endfunction

    logic [W-1:0] shadow_q [8];
    logic [W-1:0] active_q [8];
    logic         run_q, run_d;
    logic         pending_q, pending_d;
    h_state_e     h_q, h_d;
    v_state_e     v_q, v_d;
    logic [W-1:0] hcnt_q, hcnt_d, vcnt_q, vcnt_d;
    logic [W-1:0] x_q, x_d, y_q, y_d;
    logic         de_q, hs_q, vs_q, ls_q, fs_q;
    logic         h_last, v_last, wrap, apply;

    always_comb begin
        h_last = (hcnt_q == last_of(active_q[{1'b0, h_q}]));
        v_last = (vcnt_q == last_of(active_q[{1'b1, v_q}]));
        wrap   = run_q && i_en && (h_q == HS_BP) && h_last && (v_q == VS_BP) && v_last;
        apply  = pending_q && (wrap || !run_q);

        run_d  = i_en;
        h_d    = h_q;
        v_d    = v_q;
        hcnt_d = hcnt_q + ONE;
        vcnt_d = vcnt_q;
        x_d    = x_q + ONE;
        y_d    = y_q;
        if (!i_en || !run_q) begin
            h_d    = HS_VIS;
            v_d    = VS_VIS;
            hcnt_d = '0;
            vcnt_d = '0;
            x_d    = '0;
            y_d    = '0;
        end else if (h_last) begin
            hcnt_d = '0;
            h_d    = h_state_e'(h_q + 2'd1);
            if (h_q == HS_BP) begin
                x_d    = '0;
                y_d    = y_q + ONE;
                vcnt_d = vcnt_q + ONE;
                if (v_last) begin
                    vcnt_d = '0;
                    v_d    = v_state_e'(v_q + 2'd1);
                    if (v_q == VS_BP) y_d = '0;
                end
            end
        end

        // A commit landing on the apply edge re-arms for the next frame.
        if (apply)             pending_d = i_cfg_commit;
        else if (i_cfg_commit) pending_d = 1'b1;
        else                   pending_d = pending_q;
    end

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            for (int i = 0; i < 8; i++) begin
                shadow_q[i] <= dflt(i);
                active_q[i] <= dflt(i);
            end
            run_q     <= 1'b0;
            pending_q <= 1'b0;
            h_q       <= HS_VIS;
            v_q       <= VS_VIS;
            hcnt_q    <= '0;
            vcnt_q    <= '0;
            x_q       <= '0;
            y_q       <= '0;
            de_q      <= 1'b0;
            hs_q      <= ~SYNC_ON;
            vs_q      <= ~SYNC_ON;
            ls_q      <= 1'b0;
            fs_q      <= 1'b0;
        end else begin
            for (int i = 0; i < 8; i++) begin
                if (apply) active_q[i] <= shadow_q[i];
            end
            if (i_cfg_wr) shadow_q[i_cfg_addr] <= i_cfg_data;
            run_q     <= run_d;
            pending_q <= pending_d;
            h_q       <= h_d;
            v_q       <= v_d;
            hcnt_q    <= hcnt_d;
            vcnt_q    <= vcnt_d;
            x_q       <= x_d;
            y_q       <= y_d;
            de_q      <= run_d && (h_d == HS_VIS) && (v_d == VS_VIS);
            hs_q      <= (run_d && (h_d == HS_SYNC)) ? SYNC_ON : ~SYNC_ON;
            vs_q      <= (run_d && (v_d == VS_SYNC)) ? SYNC_ON : ~SYNC_ON;
            ls_q      <= run_d && (x_d == '0);
            fs_q      <= run_d && (x_d == '0) && (y_d == '0);
        end
    end

    assign o_cfg_pending = pending_q;
    assign o_h_sync      = hs_q;
    assign o_v_sync      = vs_q;
    assign o_de          = de_q;
    assign o_x           = x_q;
    assign o_y           = y_q;
    assign o_line_start  = ls_q;
    assign o_frame_start = fs_q;
endmodule

// File: tb/tb_vga_timing_sequencer.sv
// Line-level scoreboard for vga_timing_sequencer: stimulus queues expected per-line summaries,
// a negedge monitor measures each line the DUT emits and compares.
module tb_vga_timing_sequencer;
    localparam int W  = 10;
    localparam logic SA = 1'b0;
    localparam int NONE = 1023;

    logic         clk, rst_n, en, cfg_wr, cfg_commit;
    logic [2:0]   cfg_addr;
    logic [W-1:0] cfg_data;
    logic         pending, hsync, vsync, de, ls, fs;
    logic [W-1:0] x, y;

    vga_timing_sequencer dut (
        .i_clk(clk), .i_rst_n(rst_n), .i_en(en),
        .i_cfg_wr(cfg_wr), .i_cfg_addr(cfg_addr), .i_cfg_data(cfg_data),
        .i_cfg_commit(cfg_commit), .o_cfg_pending(pending),
        .o_h_sync(hsync), .o_v_sync(vsync), .o_de(de),
        .o_x(x), .o_y(y), .o_line_start(ls), .o_frame_start(fs)
    );

    typedef struct packed {
        int y; int len; int de; int hsf; int hs; int vs; int fs; int xerr;
    } rec_t;

    rec_t sb[$];
    int   n_checks = 0;
    int   n_errors = 0;

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation still running at %0t", $time);
        $fatal(1);
    end

    function automatic void chk(input string name, input int act, input int exp);
        n_checks++;
        if (act != exp) begin
            n_errors++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endfunction

    // Monitor: a line opens on o_line_start and closes on the next line start or on an idle cycle.
    rec_t cur;
    bit   open = 0;
    always @(negedge clk) begin
        automatic bit running = ls || (x != 0);
        if (open && (ls || !running)) begin
            if (sb.size() == 0) begin
                chk("unexpected_line_y", cur.y, -1);
            end else begin
                automatic rec_t e = sb.pop_front();
                n_checks++;
                if (cur != e) begin
                    n_errors++;
                    $display("FAIL line: got y=%0d len=%0d de=%0d hsf=%0d hs=%0d vs=%0d fs=%0d xerr=%0d expected y=%0d len=%0d de=%0d hsf=%0d hs=%0d vs=%0d fs=%0d xerr=%0d",
                             cur.y, cur.len, cur.de, cur.hsf, cur.hs, cur.vs, cur.fs, cur.xerr,
                             e.y, e.len, e.de, e.hsf, e.hs, e.vs, e.fs, e.xerr);
                end
            end
            if (!running)
                chk("idle_outputs", {de, hsync, vsync, fs}, {1'b0, ~SA, ~SA, 1'b0});
            open = 0;
        end
        if (ls) begin
            open = 1;
            cur  = '{y: int'(y), len: 0, de: 0, hsf: NONE, hs: 0, vs: 0, fs: int'(fs), xerr: 0};
        end
        if (open && running) begin
            if (x != cur.len || y != cur.y || (fs && cur.len != 0)) cur.xerr++;
            if (hsync == SA) begin
                if (cur.hsf == NONE) cur.hsf = int'(x);
                cur.hs++;
            end
            if (vsync == SA) cur.vs++;
            cur.de += int'(de);
            cur.len++;
        end
    end

    task automatic push_lines(input int hv, hfp, hs, hbp, vv, vfp, vs, vbp, input int y0, n);
        int ht = hv + hfp + hs + hbp;
        int vt = vv + vfp + vs + vbp;
        for (int i = 0; i < n; i++) begin
            int yy = (y0 + i) % vt;
            sb.push_back('{y: yy, len: ht, de: (yy < vv) ? hv : 0, hsf: hv + hfp, hs: hs,
                           vs: (yy >= vv + vfp && yy < vv + vfp + vs) ? ht : 0,
                           fs: (yy == 0) ? 1 : 0, xerr: 0});
        end
    endtask

    task automatic push_partial(input int yy, len, dcnt, fsv);
        sb.push_back('{y: yy, len: len, de: dcnt, hsf: NONE, hs: 0, vs: 0, fs: fsv, xerr: 0});
    endtask

    task automatic wait_pos(input int px, py, occ);
        int seen = 0;
        for (int i = 0; i < 5000 && seen < occ; i++) begin
            @(negedge clk);
            if (x == px && y == py && (x != 0 || ls)) seen++;
        end
        if (seen < occ) chk("wait_pos_timeout", seen, occ);
    endtask

    task automatic cfg(input int a, input int d);
        cfg_wr = 1'b1; cfg_addr = 3'(a); cfg_data = W'(d);
        @(negedge clk);
        cfg_wr = 1'b0;
    endtask

    task automatic commit_idle(input string tag);
        cfg_commit = 1'b1;
        @(negedge clk);
        cfg_commit = 1'b0;
        chk({tag, "_pending_set"}, int'(pending), 1);
        @(negedge clk);
        chk({tag, "_pending_applied"}, int'(pending), 0);
    endtask

    task automatic stop_idle();
        en = 1'b0;
        repeat (2) @(negedge clk);
    endtask

    initial begin
        rst_n = 1'b1; en = 1'b0; cfg_wr = 1'b0; cfg_commit = 1'b0;
        cfg_addr = '0; cfg_data = '0;
        #1 rst_n = 1'b0;
        @(negedge clk);
        chk("rst_x", int'(x), 0);
        chk("rst_y", int'(y), 0);
        chk("rst_de", int'(de), 0);
        chk("rst_hsync", int'(hsync), 1);
        chk("rst_vsync", int'(vsync), 1);
        chk("rst_strobes", int'({ls, fs}), 0);
        chk("rst_pending", int'(pending), 0);
        rst_n = 1'b1;
        @(negedge clk);

        // Default horizontal timing over the first lines, then abort at x=9 of line 3.
        push_lines(640, 16, 96, 48, 480, 10, 2, 33, 0, 3);
        push_partial(3, 10, 10, 0);
        en = 1'b1;
        wait_pos(9, 3, 1);
        stop_idle();

        // Tiny lines with default vertical fields: a whole frame of 525 lines.
        for (int i = 0; i < 4; i++) cfg(i, 1);
        commit_idle("h1111");
        push_lines(1, 1, 1, 1, 480, 10, 2, 33, 0, 525);
        push_partial(0, 1, 1, 1);
        en = 1'b1;
        wait_pos(0, 0, 2);
        stop_idle();

        // 4/1/2/1 x 3/1/1/1 mode, mid-frame reprogram of HVIS.
        cfg(0, 4); cfg(1, 1); cfg(2, 2); cfg(3, 1);
        cfg(4, 3); cfg(5, 1); cfg(6, 1); cfg(7, 1);
        commit_idle("small");
        push_lines(4, 1, 2, 1, 3, 1, 1, 1, 0, 12);
        push_lines(6, 1, 2, 1, 3, 1, 1, 1, 0, 1);
        push_partial(1, 3, 3, 0);
        en = 1'b1;
        wait_pos(3, 2, 2);
        cfg_wr = 1'b1; cfg_addr = 3'd0; cfg_data = W'(6);
        @(negedge clk);
        cfg_wr = 1'b0; cfg_commit = 1'b1;
        @(negedge clk);
        cfg_commit = 1'b0;
        chk("midframe_pending_set", int'(pending), 1);
        @(negedge clk);
        cfg_commit = 1'b1;
        @(negedge clk);
        cfg_commit = 1'b0;
        wait_pos(7, 5, 1);
        chk("pending_until_wrap", int'(pending), 1);
        @(negedge clk);
        chk("pending_clear_at_wrap", int'(pending), 0);
        chk("wrap_frame_start", int'(fs), 1);
        wait_pos(2, 1, 1);
        chk("no_rearm_after_double_commit", int'(pending), 0);
        stop_idle();

        // Zero front porch clamps to one clock; restart from idle.
        cfg(1, 0);
        commit_idle("zero_hfp");
        push_lines(6, 1, 2, 1, 3, 1, 1, 1, 0, 6);
        push_partial(0, 1, 1, 1);
        en = 1'b1;
        @(negedge clk);
        chk("restart_frame_start", int'(fs), 1);
        chk("restart_xy", int'({x, y}), 0);
        chk("restart_de", int'(de), 1);
        wait_pos(0, 0, 1);
        stop_idle();

        // Asynchronous reset mid-line; outputs must drop before the next edge.
        push_lines(6, 1, 2, 1, 3, 1, 1, 1, 0, 1);
        push_partial(1, 5, 5, 0);
        en = 1'b1;
        wait_pos(4, 1, 1);
        #2 rst_n = 1'b0;
        #1;
        chk("async_rst_x", int'(x), 0);
        chk("async_rst_y", int'(y), 0);
        chk("async_rst_de", int'(de), 0);
        chk("async_rst_hsync", int'(hsync), 1);
        en = 1'b0;
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        chk("async_rst_pending", int'(pending), 0);
        @(negedge clk);

        // Only H is reprogrammed: vertical timing must come from reset defaults.
        for (int i = 0; i < 4; i++) cfg(i, 1);
        commit_idle("post_rst");
        push_lines(1, 1, 1, 1, 480, 10, 2, 33, 0, 525);
        push_partial(0, 1, 1, 1);
        en = 1'b1;
        wait_pos(0, 0, 2);
        stop_idle();

        repeat (3) @(negedge clk);
        chk("scoreboard_drained", sb.size(), 0);
        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end
endmodule

// File: doc/vga_timing_sequencer.md
Name: vga_timing_sequencer

Overview:
Programmable VGA raster sequencer. It drives the horizontal and vertical blanking/sync timing that a VGA area tracker consumes, and produces pixel coordinates, data-enable and line/frame strobes for the pixel pipeline. Timing is configured at runtime through a shadow register bank. New settings take effect atomically on a frame boundary, so a mode change never tears a frame.

Parameters:
CNT_WIDTH, 10, width of every timing field and coordinate counter
H_VISIBLE, 640, reset value of horizontal visible length (clocks)
H_FRONT_PORCH, 16, reset value of horizontal front porch
H_SYNC, 96, reset value of horizontal sync width
H_BACK_PORCH, 48, reset value of horizontal back porch
V_VISIBLE, 480, reset value of vertical visible length (lines)
V_FRONT_PORCH, 10, reset value of vertical front porch
V_SYNC, 2, reset value of vertical sync width
V_BACK_PORCH, 33, reset value of vertical back porch
SYNC_ACTIVE, 0, logic level of an asserted sync pulse (0 = active-low)

Ports:
i_clk  in  1  pixel clock
i_rst_n  in  1  asynchronous active-low reset
i_en  in  1  run enable; low = idle at frame origin
i_cfg_wr  in  1  shadow register write strobe
i_cfg_addr  in  3  field select: 0 HVIS, 1 HFP, 2 HSYNC, 3 HBP, 4 VVIS, 5 VFP, 6 VSYNC, 7 VBP
i_cfg_data  in  CNT_WIDTH  field value (length in clocks or lines)
i_cfg_commit  in  1  request to apply shadow bank
o_cfg_pending  out  1  commit requested, not yet applied
o_h_sync  out  1  horizontal sync
o_v_sync  out  1  vertical sync
o_de  out  1  visible-area data enable
o_x  out  CNT_WIDTH  horizontal position, 0..HTOTAL-1
o_y  out  CNT_WIDTH  vertical position, 0..VTOTAL-1
o_line_start  out  1  one-cycle pulse at x=0
o_frame_start  out  1  one-cycle pulse at x=0, y=0

Behaviour:
- Reset (async, i_rst_n=0):
  - shadow and active banks load the parameter defaults
  - o_x=o_y=0, o_de=0, syncs at ~SYNC_ACTIVE, strobes=0, o_cfg_pending=0
  - position state = idle
- Line order: VISIBLE, FRONT_PORCH, SYNC, BACK_PORCH.
  - HTOTAL = sum of the four H fields; VTOTAL = sum of the four V fields.
- Each segment has an FSM state: H_VIS/H_FP/H_SYNC/H_BP and V_VIS/V_FP/V_SYNC/V_BP.
  - The V FSM advances only on the cycle the H FSM wraps from the last clock of H_BP.
- A field value of 0 is treated as 1 (clamped); no segment is ever skipped.
- The software guarantees HTOTAL, VTOTAL <= 2^CNT_WIDTH; no overflow detection is provided.
- Outputs are registered and reflect the current position, not the next one:
  - o_de = (H state H_VIS) && (V state V_VIS)
  - o_h_sync = SYNC_ACTIVE while in H_SYNC
  - o_v_sync = SYNC_ACTIVE while in V_SYNC; it changes only together with o_x=0
- Idle (i_en=0):
  - position is held at the origin, o_de=0, syncs inactive, strobes 0
  - i_en=0 mid-frame aborts the frame: next edge returns to idle with outputs deasserted
- Start: on the first edge sampling i_en=1 from idle, outputs present x=0, y=0, o_de=1, o_line_start=1, o_frame_start=1 (one-cycle latency).
  - Each subsequent enabled edge advances x by one.
  - x wraps HTOTAL-1 -> 0 and y increments; y wraps VTOTAL-1 -> 0.
- Config writes:
  - i_cfg_wr writes i_cfg_data into shadow[i_cfg_addr] at any time
  - the active bank is never touched by a write
- Commit:
  - i_cfg_commit sets o_cfg_pending on the next edge
  - a write and a commit in the same cycle: the write is included
  - commit while pending: no effect; pending stays 1
- Apply: shadow is copied to active on the edge where the position wraps (HTOTAL-1, VTOTAL-1) -> (0,0), and pending clears on that same edge.
  - When idle, apply happens on the edge after pending sets.
  - Values applied are the shadow contents at the apply edge; writes made while pending are included.
  - If commit and apply coincide on a boundary edge, the commit is deferred to the following frame.

Test Plan:
- Reset mid-run: assert i_rst_n=0 asynchronously during frame -> outputs go to reset values immediately, before the next edge; shadow returns to defaults (read back via one full frame of timing after commit).
- Defaults, i_en=1 -> o_frame_start period 420000 clocks; o_h_sync low for clocks x=656..751; o_de high for x 0..639, y 0..479; o_v_sync low for y=490..491.
- Program H=4,1,2,1 and V=3,1,1,1, commit while idle, i_en=1:
  - frame = 48 clocks; o_de high for x 0..3 in y 0..2
  - o_h_sync asserted at x=5,6 every line; o_v_sync asserted for all of y=4
- While running the 4/1/2/1 mode:
  - write HVIS=6 and commit mid-frame -> current frame unchanged; o_cfg_pending=1 until the wrap edge
  - next frame has HTOTAL=10
  - commit again during the pending window -> no extra effect
- Zero clamp: set HFP=0 and commit -> front porch behaves as 1 clock; HTOTAL = HVIS+1+HSYNC+HBP.
- Drop i_en at x=2, y=1 -> next edge: idle, o_de=0, syncs inactive; re-enable -> o_frame_start on the first cycle, x=y=0.
